scaler_stream_framer: RTL and testbench
=======================================

// Module: scaler_stream_framer
// PURPOSE
//   Downstream stage of the bilinear scaler. Takes the scaler's free-running pixel output (valid only,
//   no backpressure), tags each pixel with start-of-frame / end-of-line markers from the programmed
//   output geometry, and buffers it in a small FIFO behind a valid/ready stream to the frame writer.
//   Detects overflow and over-length frames instead of corrupting geometry.
// PARAMETERS
//   DATA_WIDTH          8   bits per channel
//   CHANNELS            3   channels per pixel; pixel word = DATA_WIDTH*CHANNELS
//   OUTPUT_X_RES_WIDTH  11  width of outputXRes / column counter
//   OUTPUT_Y_RES_WIDTH  11  width of outputYRes / line counter
//   FIFO_ADDR_WIDTH     4   FIFO depth = 2**FIFO_ADDR_WIDTH (16)
// PORTS
//   clk_fast     in   1                        pixel clock, same domain as scaler output
//   rst_n        in   1                        asynchronous, active-low reset
//   frameStart   in   1                        1-cycle pulse: begin new frame, flush state
//   outputXRes   in   OUTPUT_X_RES_WIDTH       last column index (width-1), stable during frame
//   outputYRes   in   OUTPUT_Y_RES_WIDTH       last line index (height-1), stable during frame
//   dIn          in   DATA_WIDTH*CHANNELS      pixel from scaler
//   dInValid     in   1                        pixel present this cycle; cannot be stalled
//   mOutData     out  DATA_WIDTH*CHANNELS      buffered pixel
//   mOutSof      out  1                        mOutData is pixel (0,0)
//   mOutEol      out  1                        mOutData is last pixel of a line
//   mOutValid    out  1                        mOutData/Sof/Eol valid
//   mOutReady    in   1                        consumer accepts; handshake = mOutValid & mOutReady
//   frameDone    out  1                        1-cycle pulse, final pixel of frame handed off
//   overflow     out  1                        sticky: pixel dropped because FIFO full
//   extraPixel   out  1                        sticky: pixel arrived after frame complete
//   fifoLevel    out  FIFO_ADDR_WIDTH+1        current FIFO occupancy
// BEHAVIOUR
//   Reset (rst_n=0, any time): all outputs 0, counters 0, FIFO empty, state IDLE; takes effect at once.
//   States: IDLE -frameStart-> RUN; RUN -write of last pixel-> DRAIN; DRAIN -final pop-> IDLE.
//     frameStart in any state: FIFO flushed, counters cleared, stickies cleared, state RUN next cycle;
//     a dInValid coincident with frameStart is dropped (no flag).
//   IDLE: dInValid ignored, no flags set.
//   RUN, dInValid=1: entry {sof,eol,dIn}; sof = (col==0 && line==0); eol = (col==outputXRes).
//     col increments; at col==outputXRes col->0, line+1. Last pixel = eol && line==outputYRes -> DRAIN.
//     Counters advance even when pixel dropped for overflow (geometry stays aligned to scaler).
//   Push allowed if level < depth, or level == depth and pop in same cycle; else drop, overflow<=1.
//   DRAIN, dInValid=1: pixel dropped, extraPixel<=1.
//   Output: first-word-fall-through; mOutValid = (level != 0). Pixel written at cycle N into empty
//     FIFO appears on mOut* at cycle N+1. mOut* hold stable while mOutValid & !mOutReady.
//   frameDone: asserted the cycle after the handshake of the entry with sof... no: entry with eol
//     written as last pixel (tracked by a lastPending flag); never during IDLE-only traffic.
//   fifoLevel: +1 push, -1 pop, unchanged on simultaneous push/pop; never exceeds 2**FIFO_ADDR_WIDTH.
//   Counters compare with ==; outputXRes=0 gives eol on every pixel; 0/0 gives 1-pixel frame,
//     sof and eol on same entry.
// STRUCTURE
//   scaler_pkg: state enum (IDLE/RUN/DRAIN), entry width = DATA_WIDTH*CHANNELS+2, sof/eol bit positions.
//   Sub-module scaler_sync_fifo: single-clock FWFT FIFO, async rst_n, sync flush, push/pop/level/full/empty.
//   Top: framer FSM, col/line counters, flag logic, frameDone tracking.
// TESTING
//   X=3,Y=1, 8 pixels, mOutReady=1 -> 8 outputs, Sof on #0, Eol on #3,#7, frameDone 1 cycle after #7.
//   mOutReady=0, 20 pixels, depth 16 -> fifoLevel=16, overflow=1, pixels #16-#19 absent, #0-#15 intact.
//   X=3,Y=1, 9 pixels -> 8 outputs, extraPixel=1, frameDone once, overflow=0.
//   frameStart after 5 pixels -> fifoLevel=0 next cycle, next pixel carries Sof, flags cleared.
//   Full FIFO, dInValid & mOutValid & mOutReady same cycle -> push accepted, level stays 16, no overflow.
//   rst_n low mid-frame (level=7) -> all outputs 0 immediately; after release, IDLE ignores dInValid.

Source files
------------

// File: rtl/scaler_stream_framer_pkg.sv
`default_nettype none
// ============================================================================
// scaler_stream_framer_pkg : framer state encoding and FIFO entry layout
// Rev 1.0
// ============================================================================
package scaler_stream_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } framer_state_t;

    // Entry layout is {sof, eol, pixel}; offsets are counted down from the entry MSB.
    localparam int SOF_FROM_TOP = 1;
    localparam int EOL_FROM_TOP = 2;

    function automatic int entry_width(input int data_width, input int channels);
        return data_width * channels + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scaler_sync_fifo.sv
`default_nettype none
// ============================================================================
// scaler_sync_fifo : single-clock first-word-fall-through FIFO with sync flush
// Rev 1.0
// ============================================================================
module scaler_sync_fifo #(
    parameter int WIDTH      = 26,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LEVEL_FULL = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   LEVEL_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (level == LEVEL_FULL);
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/scaler_stream_framer.sv
`default_nettype none
// ============================================================================
// scaler_stream_framer : tags scaler pixels with SOF/EOL and buffers them
//                        behind a valid/ready stream
// Rev 1.0
// ============================================================================
module scaler_stream_framer
    import scaler_stream_framer_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int CHANNELS           = 3,
    parameter int OUTPUT_X_RES_WIDTH = 11,
    parameter int OUTPUT_Y_RES_WIDTH = 11,
    parameter int FIFO_ADDR_WIDTH    = 4
) (
    input  logic                           clk_fast,
    input  logic                           rst_n,
    input  logic                           frameStart,
    input  logic [OUTPUT_X_RES_WIDTH-1:0]  outputXRes,
    input  logic [OUTPUT_Y_RES_WIDTH-1:0]  outputYRes,
    input  logic [DATA_WIDTH*CHANNELS-1:0] dIn,
    input  logic                           dInValid,
    output logic [DATA_WIDTH*CHANNELS-1:0] mOutData,
    output logic                           mOutSof,
    output logic                           mOutEol,
    output logic                           mOutValid,
    input  logic                           mOutReady,
    output logic                           frameDone,
    output logic                           overflow,
    output logic                           extraPixel,
    output logic [FIFO_ADDR_WIDTH:0]       fifoLevel
);

    localparam int PIX_W   = DATA_WIDTH * CHANNELS;
    localparam int ENTRY_W = entry_width(DATA_WIDTH, CHANNELS);
    localparam int SOF_BIT = ENTRY_W - SOF_FROM_TOP;
    localparam int EOL_BIT = ENTRY_W - EOL_FROM_TOP;
    localparam logic [OUTPUT_X_RES_WIDTH-1:0] COL_ONE   = 1;
    localparam logic [OUTPUT_Y_RES_WIDTH-1:0] LINE_ONE  = 1;
    localparam logic [FIFO_ADDR_WIDTH:0]      LEVEL_ONE = 1;

    framer_state_t                 state;
    logic [OUTPUT_X_RES_WIDTH-1:0] col;
    logic [OUTPUT_Y_RES_WIDTH-1:0] line;
    logic                          last_pending;

    logic               accept;
    logic               is_sof;
    logic               is_eol;
    logic               is_last;
    logic               pop;
    logic               push;
    logic               final_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;

    assign accept    = (state == ST_RUN) && dInValid && !frameStart;
    assign is_sof    = (col == '0) && (line == '0);
    assign is_eol    = (col == outputXRes);
    assign is_last   = is_eol && (line == outputYRes);
    assign mOutValid = !fifo_empty;
    assign pop       = mOutValid && mOutReady;
    assign push      = accept && (!fifo_full || pop);
    // The handshake that empties the FIFO is the final pop of a frame once in DRAIN.
    assign final_pop = pop && (fifoLevel == LEVEL_ONE);

    assign mOutData = mOutValid ? head[PIX_W-1:0] : '0;
    assign mOutSof  = mOutValid && head[SOF_BIT];
    assign mOutEol  = mOutValid && head[EOL_BIT];

    scaler_sync_fifo #(
        .WIDTH      (ENTRY_W),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk_fast),
        .rst_n     (rst_n),
        .flush     (frameStart),
        .push      (push),
        .push_data ({is_sof, is_eol, dIn}),
        .pop       (pop),
        .pop_data  (head),
        .level     (fifoLevel),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            col          <= '0;
            line         <= '0;
            last_pending <= 1'b0;
            frameDone    <= 1'b0;
            overflow     <= 1'b0;
            extraPixel   <= 1'b0;
        end else if (frameStart) begin
            state        <= ST_RUN;
            col          <= '0;
            line         <= '0;
            last_pending <= 1'b0;
            frameDone    <= 1'b0;
            overflow     <= 1'b0;
            extraPixel   <= 1'b0;
        end else begin
            frameDone <= final_pop && last_pending;
            if (final_pop) last_pending <= 1'b0;
            case (state)
                ST_RUN: begin
                    // Counters advance on dropped pixels too, keeping geometry locked to the scaler.
                    if (dInValid) begin
                        if (!push) overflow <= 1'b1;
                        if (is_last) begin
                            state        <= ST_DRAIN;
                            col          <= '0;
                            line         <= '0;
                            last_pending <= push;
                        end else if (is_eol) begin
                            col  <= '0;
                            line <= line + LINE_ONE;
                        end else begin
                            col <= col + COL_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (dInValid) extraPixel <= 1'b1;
                    if (final_pop || fifo_empty) state <= ST_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scaler_stream_framer.sv
`default_nettype none
// ============================================================================
// tb_scaler_stream_framer : directed table-driven bench for scaler_stream_framer
// Rev 1.0
// ============================================================================
module tb_scaler_stream_framer;

    logic        clk_fast = 1'b0;
    logic        rst_n;
    logic        frameStart;
    logic [10:0] outputXRes;
    logic [10:0] outputYRes;
    logic [23:0] dIn;
    logic        dInValid;
    logic [23:0] mOutData;
    logic        mOutSof;
    logic        mOutEol;
    logic        mOutValid;
    logic        mOutReady;
    logic        frameDone;
    logic        overflow;
    logic        extraPixel;
    logic [4:0]  fifoLevel;

    int n_cmp  = 0;
    int n_fail = 0;

    scaler_stream_framer dut (
        .clk_fast   (clk_fast),
        .rst_n      (rst_n),
        .frameStart (frameStart),
        .outputXRes (outputXRes),
        .outputYRes (outputYRes),
        .dIn        (dIn),
        .dInValid   (dInValid),
        .mOutData   (mOutData),
        .mOutSof    (mOutSof),
        .mOutEol    (mOutEol),
        .mOutValid  (mOutValid),
        .mOutReady  (mOutReady),
        .frameDone  (frameDone),
        .overflow   (overflow),
        .extraPixel (extraPixel),
        .fifoLevel  (fifoLevel)
    );

    always #5 clk_fast = ~clk_fast;

    typedef struct {
        logic        fs;
        logic        vin;
        logic [23:0] din;
        logic        rdy;
        logic        e_valid;
        logic [23:0] e_data;
        logic        e_sof;
        logic        e_eol;
        logic        e_done;
        logic [4:0]  e_level;
    } vec_t;

    vec_t vec [12];

    function automatic logic [23:0] pa(input int k);
        return 24'h102030 + 24'(k);
    endfunction

    function automatic logic [23:0] qa(input int k);
        return 24'h400000 + 24'(k);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs read then reflect the last rising edge.
    task automatic drive(input logic fs, input logic vin, input logic [23:0] d, input logic rdy);
        @(negedge clk_fast);
        frameStart = fs;
        dInValid   = vin;
        dIn        = d;
        mOutReady  = rdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int outs;
        int dones;

        rst_n = 1'b0; frameStart = 1'b0; dInValid = 1'b0; dIn = '0; mOutReady = 1'b0;
        outputXRes = 11'd3; outputYRes = 11'd1;

        // Frame X=3,Y=1 with an always-ready consumer, one row per cycle.
        vec[0]  = '{1'b1, 1'b0, 24'h0,  1'b1, 1'b0, 24'h0,  1'b0, 1'b0, 1'b0, 5'd0};
        vec[1]  = '{1'b0, 1'b1, pa(0),  1'b1, 1'b0, 24'h0,  1'b0, 1'b0, 1'b0, 5'd0};
        vec[2]  = '{1'b0, 1'b1, pa(1),  1'b1, 1'b1, pa(0),  1'b1, 1'b0, 1'b0, 5'd1};
        vec[3]  = '{1'b0, 1'b1, pa(2),  1'b1, 1'b1, pa(1),  1'b0, 1'b0, 1'b0, 5'd1};
        vec[4]  = '{1'b0, 1'b1, pa(3),  1'b1, 1'b1, pa(2),  1'b0, 1'b0, 1'b0, 5'd1};
        vec[5]  = '{1'b0, 1'b1, pa(4),  1'b1, 1'b1, pa(3),  1'b0, 1'b1, 1'b0, 5'd1};
        vec[6]  = '{1'b0, 1'b1, pa(5),  1'b1, 1'b1, pa(4),  1'b0, 1'b0, 1'b0, 5'd1};
        vec[7]  = '{1'b0, 1'b1, pa(6),  1'b1, 1'b1, pa(5),  1'b0, 1'b0, 1'b0, 5'd1};
        vec[8]  = '{1'b0, 1'b1, pa(7),  1'b1, 1'b1, pa(6),  1'b0, 1'b0, 1'b0, 5'd1};
        vec[9]  = '{1'b0, 1'b0, 24'h0,  1'b1, 1'b1, pa(7),  1'b0, 1'b1, 1'b0, 5'd1};
        vec[10] = '{1'b0, 1'b0, 24'h0,  1'b1, 1'b0, 24'h0,  1'b0, 1'b0, 1'b1, 5'd0};
        vec[11] = '{1'b0, 1'b0, 24'h0,  1'b1, 1'b0, 24'h0,  1'b0, 1'b0, 1'b0, 5'd0};

        // Reset state
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        chk("rst_valid", 32'(mOutValid), 32'd0);
        chk("rst_level", 32'(fifoLevel), 32'd0);
        chk("rst_flags", {29'd0, frameDone, overflow, extraPixel}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vec[i].fs, vec[i].vin, vec[i].din, vec[i].rdy);
            chk($sformatf("v%0d_valid", i), 32'(mOutValid), 32'(vec[i].e_valid));
            chk($sformatf("v%0d_data", i),  32'(mOutData),  32'(vec[i].e_data));
            chk($sformatf("v%0d_sof", i),   32'(mOutSof),   32'(vec[i].e_sof));
            chk($sformatf("v%0d_eol", i),   32'(mOutEol),   32'(vec[i].e_eol));
            chk($sformatf("v%0d_done", i),  32'(frameDone), 32'(vec[i].e_done));
            chk($sformatf("v%0d_level", i), 32'(fifoLevel), 32'(vec[i].e_level));
        end
        chk("t1_overflow", 32'(overflow), 32'd0);

        // Nine pixels into an eight-pixel frame
        outs = 0; dones = 0;
        drive(1'b1, 1'b0, 24'h0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            drive(1'b0, 1'b1, pa(k + 16), 1'b1);
            if (mOutValid) outs++;
            if (frameDone) dones++;
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 24'h0, 1'b1);
            if (mOutValid) outs++;
            if (frameDone) dones++;
        end
        chk("t3_outputs", 32'(outs), 32'd8);
        chk("t3_frame_done_count", 32'(dones), 32'd1);
        chk("t3_extra", 32'(extraPixel), 32'd1);
        chk("t3_overflow", 32'(overflow), 32'd0);

        // Fill to 16, push+pop on full, then overflow
        outputXRes = 11'd31;
        drive(1'b1, 1'b0, 24'h0, 1'b0);
        for (int k = 0; k < 16; k++) drive(1'b0, 1'b1, qa(k), 1'b0);
        drive(1'b0, 1'b1, qa(16), 1'b1);
        chk("t5_level_full", 32'(fifoLevel), 32'd16);
        chk("t5_head", 32'(mOutData), 32'(qa(0)));
        chk("t5_head_sof", 32'(mOutSof), 32'd1);
        drive(1'b0, 1'b1, qa(17), 1'b0);
        chk("t5_level_after_pushpop", 32'(fifoLevel), 32'd16);
        chk("t5_no_overflow", 32'(overflow), 32'd0);
        chk("t5_head_next", 32'(mOutData), 32'(qa(1)));
        for (int k = 18; k < 21; k++) drive(1'b0, 1'b1, qa(k), 1'b0);
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_level", 32'(fifoLevel), 32'd16);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 1'b0, 24'h0, 1'b1);
            chk($sformatf("t2_data%0d", k), 32'(mOutData), 32'(qa(k)));
            chk($sformatf("t2_valid%0d", k), 32'(mOutValid), 32'd1);
        end
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        chk("t2_empty", 32'(mOutValid), 32'd0);

        // frameStart after 5 pixels, coincident pixel dropped
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, pa(k + 32), 1'b0);
        drive(1'b1, 1'b1, 24'hBADBAD, 1'b0);
        chk("t4_level_before", 32'(fifoLevel), 32'd5);
        chk("t4_overflow_before", 32'(overflow), 32'd1);
        drive(1'b0, 1'b1, 24'h00C0DE, 1'b0);
        chk("t4_level_flushed", 32'(fifoLevel), 32'd0);
        chk("t4_flags_cleared", {30'd0, overflow, extraPixel}, 32'd0);
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        chk("t4_level1", 32'(fifoLevel), 32'd1);
        chk("t4_sof", 32'(mOutSof), 32'd1);
        chk("t4_data", 32'(mOutData), 32'h00C0DE);

        // Reset mid-frame with level 7
        for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, pa(k + 48), 1'b0);
        drive(1'b0, 1'b0, 24'h0, 1'b0);
        chk("t6_level7", 32'(fifoLevel), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_level", 32'(fifoLevel), 32'd0);
        chk("t6_rst_valid", 32'(mOutValid), 32'd0);
        chk("t6_rst_data", 32'(mOutData), 32'd0);
        chk("t6_rst_tags", {30'd0, mOutSof, mOutEol}, 32'd0);
        drive(1'b0, 1'b1, 24'h123456, 1'b1);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, pa(k + 64), 1'b1);
        drive(1'b0, 1'b0, 24'h0, 1'b1);
        chk("t6_idle_level", 32'(fifoLevel), 32'd0);
        chk("t6_idle_valid", 32'(mOutValid), 32'd0);
        chk("t6_idle_flags", {29'd0, frameDone, overflow, extraPixel}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
